srf_write_arbiter: RTL

//  Round-robin scheduler sharing the single SRF write port among NUM_REQ producers (ICU, VXM result, data-memory load).
//  A grant covers one whole vector transfer: 1..NUM_TILES_PER_SLICE beats of MIN_VEC_LENGTH bytes each.
//  The grant is held until the last beat, then rotates. Sits between the icu_dispatcher-controlled datapaths and the SRF.

---
 rtl/srf_write_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/srf_write_arbiter.sv
// Round-robin owner of the single SRF write port: one grant covers a whole
// vector transfer of 1..NUM_TILES_PER_SLICE beats, then the pointer rotates.
module srf_write_arbiter #(
    parameter int NUM_REQ             = 3,
    parameter int NUM_STREAM_ID       = 5,
    parameter int NUM_VECTORS         = 5,
    parameter int MIN_VEC_LENGTH      = 16,
    parameter int NUM_TILES_PER_SLICE = 20,
    parameter int DATA_WIDTH          = 8 * MIN_VEC_LENGTH,
    parameter int GW                  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*NUM_STREAM_ID-1:0]  req_stream,
    input  logic [NUM_REQ*NUM_VECTORS-1:0]    req_length,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              srf_write_enable,
    output logic [NUM_STREAM_ID-1:0]          srf_write_stream,
    output logic [DATA_WIDTH-1:0]             srf_write_data,
    output logic [GW-1:0]                     grant_id,
    output logic                              busy,
    output logic                              burst_done
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            ptr_q, ptr_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [NUM_STREAM_ID-1:0] stream_q, stream_d;
    logic [NUM_VECTORS-1:0]   beats_q, beats_d;
    logic                     we_q, we_d;
    logic                     done_q, done_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;

    logic [NUM_STREAM_ID-1:0] stream_arr [NUM_REQ];
    logic [NUM_VECTORS-1:0]   len_arr    [NUM_REQ];
    logic [DATA_WIDTH-1:0]    data_arr   [NUM_REQ];

    logic          found;
    logic [GW-1:0] pick;
    int            idx;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign stream_arr[gi] = req_stream[gi*NUM_STREAM_ID +: NUM_STREAM_ID];
        assign len_arr[gi]    = req_length[gi*NUM_VECTORS +: NUM_VECTORS];
        assign data_arr[gi]   = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        // Ready is forced low while reset is asserted, even mid-burst.
        assign req_ready[gi]  = !rst && (state_q == BURST) && (grant_q == GW'(gi));
    end

    function automatic logic [NUM_VECTORS-1:0] eff_len(input logic [NUM_VECTORS-1:0] len);
        if (len == '0)
            return NUM_VECTORS'(1);
        else if (len > NUM_VECTORS'(NUM_TILES_PER_SLICE))
            return NUM_VECTORS'(NUM_TILES_PER_SLICE);
        else
            return len;
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        stream_d = stream_q;
        beats_d  = beats_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    stream_d = stream_arr[pick];
                    beats_d  = eff_len(len_arr[pick]);
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (req_valid[grant_q]) begin
                    we_d   = 1'b1;
                    data_d = data_arr[grant_q];
                    if (beats_q == NUM_VECTORS'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    end else begin
                        beats_d = beats_q - NUM_VECTORS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            stream_q <= '0;
            beats_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            stream_q <= stream_d;
            beats_q  <= beats_d;
            we_q     <= we_d;
            done_q   <= done_d;
            data_q   <= data_d;
        end
    end

    assign srf_write_enable = we_q;
    assign srf_write_stream = stream_q;
    assign srf_write_data   = data_q;
    assign grant_id         = grant_q;
    assign busy             = (state_q == BURST);
    assign burst_done       = done_q;

endmodule
